fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter sequencer for the single-cycle core. It drives the instruction ROM address and qualifies each fetched word as valid for decode.
- It applies the next-PC rules every cycle: sequential, absolute branch, relative branch, stall and halt.
- It tracks retired-instruction count and run status for the testbench and top level.
- It sits between top-level Start/Done and the ROM/decode stage. The ROM read is combinational, so the word at InstAddress is valid in the same cycle.

Parameters:
- A, 10, instruction address width (ROM depth 2**A)
- OW, 6, signed relative-branch offset width
- CW, 16, retired-instruction counter width

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin execution at StartAddr; sampled only in IDLE or HALTED.
- StartAddr  input  A  first instruction address.
- Stall  input  1  freeze PC and counter this cycle.
- HaltReq  input  1  decode detected halt opcode at current PC.
- BranchEn  input  1  branch taken this cycle.
- BranchRel  input  1  1 = relative (PC + Offset), 0 = absolute (Target).
- Target  input  A  absolute branch target.
- Offset  input  OW  two's-complement relative offset.
- InstAddress  output  A  registered PC, driven straight to the ROM address.
- InstValid  output  1  ROM output at InstAddress is an instruction to execute this cycle.
- Done  output  1  program halted.
- InstCount  output  CW  instructions retired since last Start; saturating.
- PcWrap  output  1  sticky flag: PC wrapped across the address space.

Behaviour:
- States: IDLE, RUN, HALTED. Encoding is free.
- Reset (async, Reset=1): state=IDLE, InstAddress=0, Done=0, InstCount=0, PcWrap=0. Reset dominates everything, including mid-RUN.
- Outputs:
  - InstValid = (state==RUN) & ~Stall. It is combinational from state and Stall only.
  - Done = (state==HALTED). It is registered.
- IDLE:
  - Start=1 -> next edge: state=RUN, PC=StartAddr, InstCount=0, PcWrap=0.
  - All other inputs are ignored.
- RUN: the priority per edge is Stall > HaltReq > BranchEn > sequential.
  - Stall=1: PC, InstCount and state hold. HaltReq and BranchEn are ignored.
  - HaltReq=1: state=HALTED, PC holds (points at the halt instruction). InstCount increments; the halt counts as retired.
  - BranchEn=1 & BranchRel=0: PC=Target.
  - BranchEn=1 & BranchRel=1: PC = (PC + sign-extend(Offset)) mod 2**A.
    - Set PcWrap if the true sum is <0 or >2**A-1.
  - Otherwise: PC=(PC+1) mod 2**A. Set PcWrap when PC was 2**A-1.
  - Every non-stalled RUN cycle increments InstCount. It saturates at 2**CW-1 and never wraps.
  - Start is ignored in RUN.
- HALTED:
  - Done=1, PC and InstCount hold.
  - Start=1 -> RUN exactly as from IDLE (PC=StartAddr, counter and PcWrap cleared, Done falls on the same edge).
- PcWrap is sticky. Only Reset and an accepted Start clear it. Execution continues after a wrap.
- Latency:
  - Next-PC decision is made in cycle N and visible on InstAddress in cycle N+1.
  - First InstValid is the cycle after Start is accepted.
- Branch to the current PC (Target==PC, or Offset==0) is legal and produces a tight loop. InstCount still increments.

Test Plan:
- Reset then Start=1 with StartAddr=0, no branches, HaltReq at PC=4. Expect:
  - InstAddress 0,1,2,3,4 on consecutive cycles with InstValid=1.
  - Done=1 from the cycle after PC=4, InstCount=5, InstAddress holds 4.
- Branches. Expect:
  - Absolute branch at PC=3 with Target=0x2A: next InstAddress=0x2A.
  - Relative branch at PC=0x2A with Offset=-2 (6'b111110): next InstAddress=0x28, PcWrap=0.
- Stall=1 for 3 cycles at PC=7 while BranchEn=1 and HaltReq=1 are asserted. Expect:
  - PC stays 7, InstValid=0, InstCount unchanged.
  - After Stall drops with both requests gone, PC=8.
- Wrap. Expect:
  - StartAddr=0x3FF, sequential step: InstAddress=0x000, PcWrap=1 and stays 1.
  - Relative Offset=-1 at PC=0: InstAddress=0x3FF, PcWrap=1.
  - A later Start clears PcWrap to 0.
- Assert Reset asynchronously mid-RUN (PC=0x15, InstCount=9, between clock edges). Expect:
  - Immediately: InstAddress=0, InstCount=0, Done=0, InstValid=0, state IDLE.
  - Start during HALTED restarts the run with Done falling on the accepting edge.
- Counter saturation with CW=4: run 20 non-stalled instructions. Expect InstCount to stop at 15, not wrap to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer for the single-cycle core.
//   Drives the instruction ROM address from a registered PC and qualifies the
//   combinational ROM word as valid for decode. It applies the next-PC rules
//   (sequential, absolute or relative branch, stall, halt) and tracks the
//   retired-instruction count and run status.
// Ports:
//   Clk, Reset              rising-edge clock, async active-high reset
//   Start, StartAddr        begin a run (accepted only in IDLE / HALTED)
//   Stall                   freeze PC and counter this cycle
//   HaltReq                 halt opcode decoded at current PC
//   BranchEn, BranchRel     branch taken; 1 = PC+Offset, 0 = Target
//   Target, Offset          absolute target / signed relative offset
//   InstAddress             registered PC to the ROM
//   InstValid               ROM word at InstAddress executes this cycle
//   Done                    program halted (registered)
//   InstCount               saturating retired-instruction count
//   PcWrap                  sticky: PC wrapped across the address space
module fetch_sequencer #(
    parameter int A  = 10,
    parameter int OW = 6,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [A-1:0]  StartAddr,
    input  logic          Stall,
    input  logic          HaltReq,
    input  logic          BranchEn,
    input  logic          BranchRel,
    input  logic [A-1:0]  Target,
    input  logic [OW-1:0] Offset,
    output logic [A-1:0]  InstAddress,
    output logic          InstValid,
    output logic          Done,
    output logic [CW-1:0] InstCount,
    output logic          PcWrap
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [A-1:0]  pc_q,    pc_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          wrap_q,  wrap_d;
    logic          done_q,  done_d;

    // Two extra bits hold the true relative sum: bit A+1 set means it went
    // negative, bit A set (with A+1 clear) means it passed 2**A-1.
    logic [A+1:0]  rel_sum;

    assign rel_sum = {2'b00, pc_q} + {{(A+2-OW){Offset[OW-1]}}, Offset};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = StartAddr;
                    cnt_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (!Stall) begin
                    // Halt counts as retired; counter sticks at all-ones.
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    if (HaltReq) begin
                        state_d = S_HALTED;
                    end else if (BranchEn) begin
                        if (BranchRel) begin
                            pc_d = rel_sum[A-1:0];
                            if (rel_sum[A+1] || rel_sum[A]) wrap_d = 1'b1;
                        end else begin
                            pc_d = Target;
                        end
                    end else begin
                        pc_d = pc_q + 1'b1;
                        if (&pc_q) wrap_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_HALTED);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign InstAddress = pc_q;
    assign InstValid   = (state_q == S_RUN) && !Stall;
    assign Done        = done_q;
    assign InstCount   = cnt_q;
    assign PcWrap      = wrap_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Expected post-edge state is pushed to a
// scoreboard queue as each step's stimulus is driven and popped after the edge.
// A second instance with CW=4 shares the inputs for the saturation check.
module tb_fetch_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic [9:0] StartAddr = '0;
    logic       Stall = 1'b0;
    logic       HaltReq = 1'b0;
    logic       BranchEn = 1'b0;
    logic       BranchRel = 1'b0;
    logic [9:0] Target = '0;
    logic [5:0] Offset = '0;

    logic [9:0]  InstAddress, InstAddress4;
    logic        InstValid, InstValid4;
    logic        Done, Done4;
    logic [15:0] InstCount;
    logic [3:0]  InstCount4;
    logic        PcWrap, PcWrap4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int a;
        int c;
        bit d;
        bit w;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;

    fetch_sequencer #(.A(10), .OW(6), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .HaltReq(HaltReq), .BranchEn(BranchEn),
        .BranchRel(BranchRel), .Target(Target), .Offset(Offset),
        .InstAddress(InstAddress), .InstValid(InstValid), .Done(Done),
        .InstCount(InstCount), .PcWrap(PcWrap)
    );

    fetch_sequencer #(.A(10), .OW(6), .CW(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .HaltReq(HaltReq), .BranchEn(BranchEn),
        .BranchRel(BranchRel), .Target(Target), .Offset(Offset),
        .InstAddress(InstAddress4), .InstValid(InstValid4), .Done(Done4),
        .InstCount(InstCount4), .PcWrap(PcWrap4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        Start = 0; Stall = 0; HaltReq = 0; BranchEn = 0; BranchRel = 0;
    endtask

    // One clock: check InstValid for the inputs now applied, then compare the
    // post-edge PC/count/done/wrap against the scoreboard entry.
    task automatic step(input bit v, input int a, input int c, input bit d,
                        input bit w);
        exp_t e;
        e.a = a; e.c = c; e.d = d; e.w = w;
        sb.push_back(e);
        #1;
        chk("valid", 32'(InstValid), 32'(v));
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("addr",  32'(InstAddress), e.a);
        chk("count", 32'(InstCount),   e.c);
        chk("done",  32'(Done),        32'(e.d));
        chk("wrap",  32'(PcWrap),      32'(e.w));
    endtask

    initial begin
        // Asynchronous reset state
        #1 Reset = 1;
        #2;
        chk("rst_addr",  32'(InstAddress), 0);
        chk("rst_count", 32'(InstCount), 0);
        chk("rst_done",  32'(Done), 0);
        chk("rst_wrap",  32'(PcWrap), 0);
        chk("rst_valid", 32'(InstValid), 0);
        @(posedge Clk);
        #1 Reset = 0;

        // Straight-line run 0..4, halt at 4
        Start = 1; StartAddr = 10'h000;
        step(0, 'h000, 0, 0, 0);
        idle_inputs();
        step(1, 'h001, 1, 0, 0);
        step(1, 'h002, 2, 0, 0);
        step(1, 'h003, 3, 0, 0);
        step(1, 'h004, 4, 0, 0);
        HaltReq = 1;
        step(1, 'h004, 5, 1, 0);
        idle_inputs();
        step(0, 'h004, 5, 1, 0);

        // Restart from HALTED at 3; Done falls on the accepting edge
        Start = 1; StartAddr = 10'h003;
        step(0, 'h003, 0, 0, 0);
        idle_inputs();

        // Absolute then relative (-2) branch
        BranchEn = 1; BranchRel = 0; Target = 10'h02A;
        step(1, 'h02A, 1, 0, 0);
        BranchRel = 1; Offset = 6'b111110;
        step(1, 'h028, 2, 0, 0);
        BranchRel = 0; Target = 10'h007;
        step(1, 'h007, 3, 0, 0);

        // Stall dominates branch and halt
        Stall = 1; HaltReq = 1; BranchEn = 1; Target = 10'h100;
        for (int i = 0; i < 3; i++) step(0, 'h007, 3, 0, 0);
        idle_inputs();
        step(1, 'h008, 4, 0, 0);

        // Tight loop via Offset=0, Start ignored in RUN, then halt
        BranchEn = 1; BranchRel = 1; Offset = 6'b000000;
        step(1, 'h008, 5, 0, 0);
        idle_inputs();
        Start = 1; StartAddr = 10'h055;
        step(1, 'h009, 6, 0, 0);
        idle_inputs();
        HaltReq = 1;
        step(1, 'h009, 7, 1, 0);
        idle_inputs();

        // Sequential wrap from 0x3FF; flag is sticky
        Start = 1; StartAddr = 10'h3FF;
        step(0, 'h3FF, 0, 0, 0);
        idle_inputs();
        step(1, 'h000, 1, 0, 1);
        step(1, 'h001, 2, 0, 1);
        HaltReq = 1;
        step(1, 'h001, 3, 1, 1);
        idle_inputs();

        // Start clears wrap; relative -1 at PC=0 wraps below zero
        Start = 1; StartAddr = 10'h000;
        step(0, 'h000, 0, 0, 0);
        idle_inputs();
        BranchEn = 1; BranchRel = 1; Offset = 6'b111111;
        step(1, 'h3FF, 1, 0, 1);
        idle_inputs();
        HaltReq = 1;
        step(1, 'h3FF, 2, 1, 1);
        idle_inputs();

        // Relative +31 from 0x3F0 wraps above the top
        Start = 1; StartAddr = 10'h3F0;
        step(0, 'h3F0, 0, 0, 0);
        idle_inputs();
        BranchEn = 1; BranchRel = 1; Offset = 6'b011111;
        step(1, 'h00F, 1, 0, 1);
        idle_inputs();
        HaltReq = 1;
        step(1, 'h00F, 2, 1, 1);
        idle_inputs();

        // Run to PC=0x15 / count 9, then async reset between edges
        Start = 1; StartAddr = 10'h00C;
        step(0, 'h00C, 0, 0, 0);
        idle_inputs();
        for (int i = 1; i <= 9; i++) step(1, 'h00C + i, i, 0, 0);
        #2 Reset = 1;
        #1;
        chk("mid_rst_addr",  32'(InstAddress), 0);
        chk("mid_rst_count", 32'(InstCount), 0);
        chk("mid_rst_done",  32'(Done), 0);
        chk("mid_rst_valid", 32'(InstValid), 0);
        #1 Reset = 0;
        @(posedge Clk);
        #1;

        // IDLE ignores everything but Start
        HaltReq = 1; BranchEn = 1; Target = 10'h005;
        step(0, 'h000, 0, 0, 0);
        idle_inputs();

        // Counter saturation on the CW=4 instance
        Start = 1; StartAddr = 10'h100;
        step(0, 'h100, 0, 0, 0);
        idle_inputs();
        for (int i = 1; i <= 20; i++) begin
            step(1, 'h100 + i, i, 0, 0);
            chk("sat_count4", 32'(InstCount4), (i > 15) ? 15 : i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
